// File: rtl/bram_if.sv
// rtl/bram_if.sv - single-port BRAM bus between controller (master) and responder (slave)
//
// Signals:
//   addr0    controller -> responder  access address
//   ce0      controller -> responder  access enable
//   we0      controller -> responder  1 = write, 0 = read (with ce0)
//   d0       controller -> responder  write data
//   q0       responder -> controller  returned read data (held between returns)
//   q0_valid responder -> controller  q0 carries a returned read this cycle
interface bram_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12
);
  logic [AWIDTH-1:0] addr0;
  logic              ce0;
  logic              we0;
  logic [DWIDTH-1:0] d0;
  logic [DWIDTH-1:0] q0;
  logic              q0_valid;

  modport master (
    output addr0, ce0, we0, d0,
    input  q0, q0_valid
  );

  modport slave (
    input  addr0, ce0, we0, d0,
    output q0, q0_valid
  );
endinterface

// File: rtl/bram_responder.sv
// rtl/bram_responder.sv - single-port BRAM responder with read latency pipeline, OOB flag and counters
//
// Ports:
//   clk         single rising-edge clock
//   reset_n     asynchronous active-low reset
//   bus         bram_if.slave: addr0/ce0/we0/d0 in, q0/q0_valid out
//   i_clr       synchronous clear of status and counters (priority over accesses)
//   o_err_oob   sticky flag: an access with addr0 >= MEM_SIZE happened
//   o_err_addr  address of the first out-of-range access since reset/clear
//   o_wr_cnt    saturating count of accepted writes (out-of-range included)
//   o_rd_cnt    saturating count of accepted reads (out-of-range included)
module bram_responder #(
  parameter int DWIDTH     = 16,
  parameter int AWIDTH     = 12,
  parameter int MEM_SIZE   = 3840,
  parameter int RD_LATENCY = 1,
  parameter int CWIDTH     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  bram_if.slave             bus,
  input  logic              i_clr,
  output logic              o_err_oob,
  output logic [AWIDTH-1:0] o_err_addr,
  output logic [CWIDTH-1:0] o_wr_cnt,
  output logic [CWIDTH-1:0] o_rd_cnt
);

  // Illegal configurations stop elaboration rather than building something odd.
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("bram_responder: RD_LATENCY must be in 1..4");
  end
  if (MEM_SIZE < 1 || MEM_SIZE > (1 << AWIDTH)) begin : g_bad_mem_size
    $error("bram_responder: MEM_SIZE must be in 1..2^AWIDTH");
  end

  // One extra bit so MEM_SIZE == 2^AWIDTH is representable and nothing is OOB.
  localparam logic [AWIDTH:0]   MEM_LIMIT = (AWIDTH + 1)'(MEM_SIZE);
  localparam logic [CWIDTH-1:0] CNT_MAX   = '1;

  // Access decode
  logic              wr;
  logic              rd;
  logic              oob;
  logic [DWIDTH-1:0] rd_word;

  assign wr  = bus.ce0 &  bus.we0;
  assign rd  = bus.ce0 & ~bus.we0;
  assign oob = bus.ce0 & ({1'b0, bus.addr0} >= MEM_LIMIT);

  // Storage: no reset so contents survive reset_n.
  logic [DWIDTH-1:0] mem [0:MEM_SIZE-1];

  always_ff @(posedge clk) begin
    if (wr && !oob) begin
      mem[bus.addr0] <= bus.d0;
    end
  end

  // Out-of-range reads return zero instead of touching the array.
  assign rd_word = oob ? '0 : mem[bus.addr0];

  // Read pipeline: stage 0 samples the array at the request edge, the last
  // stage is the output register. Stage data only advances with its valid,
  // which is what makes q0 hold the last returned value between reads.
  logic [RD_LATENCY-1:0] pipe_vld;
  logic [DWIDTH-1:0]     pipe_data [RD_LATENCY];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= rd;
      if (rd) begin
        pipe_data[0] <= rd_word;
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        if (pipe_vld[i-1]) begin
          pipe_data[i] <= pipe_data[i-1];
        end
      end
    end
  end

  assign bus.q0       = pipe_data[RD_LATENCY-1];
  assign bus.q0_valid = pipe_vld[RD_LATENCY-1];

  // Status and counters. Clear wins over an access in the same cycle, so that
  // access is neither counted nor flagged; the array write itself still lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_err_oob  <= 1'b0;
      o_err_addr <= '0;
      o_wr_cnt   <= '0;
      o_rd_cnt   <= '0;
    end else if (i_clr) begin
      o_err_oob  <= 1'b0;
      o_err_addr <= '0;
      o_wr_cnt   <= '0;
      o_rd_cnt   <= '0;
    end else begin
      // Only the first OOB access is recorded until the next clear.
      if (oob && !o_err_oob) begin
        o_err_oob  <= 1'b1;
        o_err_addr <= bus.addr0;
      end
      if (wr && (o_wr_cnt != CNT_MAX)) begin
        o_wr_cnt <= o_wr_cnt + CWIDTH'(1);
      end
      if (rd && (o_rd_cnt != CNT_MAX)) begin
        o_rd_cnt <= o_rd_cnt + CWIDTH'(1);
      end
    end
  end

endmodule
